// File: rtl/mc_arm_controller.sv
// ---------------------------------------------------------------------------
// mc_arm_controller
// Control unit for the multi-cycle ARM datapath. Contains the main FSM, the
// ALU decoder, the conditional-execution check and the NZCV flag registers.
//
// Ports
//   clk         in   1  clock, all state updates on the rising edge
//   RESET       in   1  synchronous active-high reset
//   ALUFlags    in   4  {N,Z,C,V} from the ALU
//   Cond        in   4  instr[31:28]
//   Op          in   2  instr[27:26]
//   Funct       in   6  instr[25:20]
//   Rd          in   4  instr[15:12]
//   PCWrite     out  1  PC register enable
//   AdrSrc      out  1  memory address select (0 PC, 1 ALUOut)
//   MemWrite    out  1  data memory write enable
//   IRWrite     out  1  instruction register enable
//   ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUControl  out  4  AND 0000, SUB 0010, ADD 0100, ORR 1100, MOV 1101
//   ALUSrcA     out  1  0 reg A, 1 PC
//   ALUSrcB     out  2  00 reg B, 01 ExtImm, 10 constant 4
//   ImmSrc      out  2  immediate extension select (equals Op)
//   RegWrite    out  1  register file write enable
//   RegSrc      out  2  register file read-address selects
//   BL_ctrl     out  1  branch-with-link control, tied low
// ---------------------------------------------------------------------------
module mc_arm_controller (
    input  logic       clk,
    input  logic       RESET,
    input  logic [3:0] ALUFlags,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [3:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [1:0] RegSrc,
    output logic       BL_ctrl
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    logic [3:0] r_state;
    logic [3:0] w_state_next;

    // Raw per-state controls before condition gating
    logic       w_nextpc;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_aluop;

    logic [1:0] w_flagw;
    logic [1:0] w_flagwrite;
    logic       w_condex;
    logic       w_pcs;
    logic       r_condex_q;
    logic [3:0] r_flags;
    logic       w_unused_flags;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (any unused encoding falls back to FETCH)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   w_state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_state_next = S_MEMADR;
                    2'b10:   w_state_next = S_BRANCH;
                    default: w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_state_next = S_MEMWB;
            S_EXECUTER: w_state_next = S_ALUWB;
            S_EXECUTEI: w_state_next = S_ALUWB;
            default:    w_state_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: per-state outputs
    // ------------------------------------------------------------------
    always_comb begin
        IRWrite   = 1'b0;
        w_nextpc  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        w_aluop   = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_branch  = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                w_nextpc  = 1'b1;
                ResultSrc = 2'b10;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
            end
            S_DECODE: begin
                ResultSrc = 2'b10;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                w_regw    = 1'b1;
                ResultSrc = 2'b01;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            S_EXECUTER: w_aluop = 1'b1;
            S_EXECUTEI: begin
                w_aluop = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_ALUWB:    w_regw = 1'b1;
            S_BRANCH: begin
                w_branch  = 1'b1;
                ResultSrc = 2'b10;
                ALUSrcB   = 2'b01;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder. Non-ALU states always add (PC+4, address calc, branch
    // target). FlagW[1] covers N,Z; FlagW[0] covers C,V.
    // ------------------------------------------------------------------
    always_comb begin
        ALUControl = ALU_ADD;
        w_flagw    = 2'b00;
        if (w_aluop) begin
            case (Funct[4:0])
                5'b01000: begin ALUControl = ALU_ADD; w_flagw = 2'b00; end
                5'b01001: begin ALUControl = ALU_ADD; w_flagw = 2'b11; end
                5'b00100: begin ALUControl = ALU_SUB; w_flagw = 2'b00; end
                5'b00101: begin ALUControl = ALU_SUB; w_flagw = 2'b11; end
                5'b00000: begin ALUControl = ALU_AND; w_flagw = 2'b00; end
                5'b00001: begin ALUControl = ALU_AND; w_flagw = 2'b10; end
                5'b11000: begin ALUControl = ALU_ORR; w_flagw = 2'b00; end
                5'b11001: begin ALUControl = ALU_ORR; w_flagw = 2'b10; end
                5'b11010: begin ALUControl = ALU_MOV; w_flagw = 2'b00; end
                5'b11011: begin ALUControl = ALU_MOV; w_flagw = 2'b10; end
                5'b10100: begin ALUControl = ALU_SUB; w_flagw = 2'b00; end
                5'b10101: begin ALUControl = ALU_SUB; w_flagw = 2'b11; end
                default:  begin ALUControl = ALU_SUB; w_flagw = 2'b11; end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Condition check against the stored flags (only EQ/NE/AL supported)
    // ------------------------------------------------------------------
    always_comb begin
        case (Cond)
            4'b0000: w_condex = r_flags[2];
            4'b0001: w_condex = ~r_flags[2];
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // N,C,V are stored for completeness but not consulted by the reduced
    // condition set above.
    assign w_unused_flags = ^{r_flags[3], r_flags[1:0]};

    // ------------------------------------------------------------------
    // Flag registers: two independent 2-bit enable registers, {N,Z} and {C,V}
    // ------------------------------------------------------------------
    assign w_flagwrite = w_flagw & {2{w_condex}};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_reg
            always_ff @(posedge clk) begin
                if (RESET) begin
                    r_flags[gi*2 +: 2] <= 2'b00;
                end else if (w_flagwrite[gi]) begin
                    r_flags[gi*2 +: 2] <= ALUFlags[gi*2 +: 2];
                end
            end
        end
    endgenerate

    // Condition result is registered so the write-back/branch cycle uses the
    // verdict formed before this instruction's own flag update.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_condex_q <= 1'b0;
        end else begin
            r_condex_q <= w_condex;
        end
    end

    // ------------------------------------------------------------------
    // Conditional write gating
    // ------------------------------------------------------------------
    assign w_pcs    = ((Rd == 4'd15) & w_regw) | w_branch;
    assign PCWrite  = w_nextpc | (w_pcs & r_condex_q);
    assign RegWrite = w_regw & r_condex_q;
    assign MemWrite = w_memw & r_condex_q;

    assign ImmSrc  = Op;
    assign BL_ctrl = 1'b0;

    always_comb begin
        case (Op)
            2'b10:   RegSrc = 2'b01;
            2'b01:   RegSrc = 2'b10;
            default: RegSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mc_arm_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_arm_controller
// Drives instruction fields cycle by cycle as the instruction register would,
// predicts every cycle's control outputs from an instruction-level model, and
// compares them in a separate monitor process.
// ---------------------------------------------------------------------------
module tb_mc_arm_controller;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       RESET;
    logic [3:0] ALUFlags;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, BL_ctrl;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0] ALUControl;

    mc_arm_controller dut (
        .clk       (clk),
        .RESET     (RESET),
        .ALUFlags  (ALUFlags),
        .Cond      (Cond),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUControl(ALUControl),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .RegSrc    (RegSrc),
        .BL_ctrl   (BL_ctrl)
    );

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB,
        P_MEMWRITE, P_EXECR, P_EXECI, P_ALUWB, P_BRANCH
    } phase_t;

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] flg;   // ALUFlags presented during the execute cycle
    } instr_t;

    typedef struct {
        logic [18:0] exp;
        string       name;
    } exp_t;

    exp_t       sb_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] model_flags;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUControl,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,RegSrc,BL_ctrl}
    wire [18:0] w_got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                         ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc, BL_ctrl};

    function automatic bit cond_ok(input logic [3:0] c, input logic z);
        if (c == 4'b0000) return z;
        if (c == 4'b0001) return !z;
        return (c == 4'b1110);
    endfunction

    // Decode by command + S bit rather than the flat 5-bit table.
    function automatic void alu_model(input logic [5:0] f, output logic [3:0] ctl,
                                      output logic [1:0] fw);
        logic [3:0] cmd;
        bit         arith;
        cmd   = f[4:1];
        arith = 1'b0;
        ctl   = 4'b0010;
        fw    = 2'b11;
        case (cmd)
            4'b0100: begin ctl = 4'b0100; arith = 1'b1; end   // ADD
            4'b0010: begin ctl = 4'b0010; arith = 1'b1; end   // SUB
            4'b1010: begin ctl = 4'b0010; arith = 1'b1; end   // CMP
            4'b0000: ctl = 4'b0000;                           // AND
            4'b1100: ctl = 4'b1100;                           // ORR
            4'b1101: ctl = 4'b1101;                           // MOV
            default: return;                                  // SUB, flags 11
        endcase
        fw = f[0] ? (arith ? 2'b11 : 2'b10) : 2'b00;
    endfunction

    function automatic logic [18:0] expect_out(input phase_t ph, input instr_t in,
                                               input bit pass, input logic [3:0] ctl);
        logic       pcw, adr, memw, irw, srca, regw;
        logic [1:0] res, srcb, rsrc;
        logic [3:0] aluc;
        pcw = 0; adr = 0; memw = 0; irw = 0; srca = 0; regw = 0;
        res = 2'b00; srcb = 2'b00; aluc = 4'b0100;
        case (ph)
            P_FETCH:    begin irw = 1; pcw = 1; res = 2'b10; srca = 1; srcb = 2'b10; end
            P_DECODE:   begin res = 2'b10; srca = 1; srcb = 2'b10; end
            P_MEMADR:   srcb = 2'b01;
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin res = 2'b01; regw = pass; pcw = pass && (in.rd == 4'd15); end
            P_MEMWRITE: begin adr = 1; memw = pass; end
            P_EXECR:    aluc = ctl;
            P_EXECI:    begin aluc = ctl; srcb = 2'b01; end
            P_ALUWB:    begin regw = pass; pcw = pass && (in.rd == 4'd15); end
            P_BRANCH:   begin pcw = pass; res = 2'b10; srcb = 2'b01; end
            default: ;
        endcase
        rsrc = (in.op == 2'b10) ? 2'b01 : (in.op == 2'b01) ? 2'b10 : 2'b00;
        return {pcw, adr, memw, irw, res, aluc, srca, srcb, in.op, regw, rsrc, 1'b0};
    endfunction

    // Issue one instruction; abort_at >= 0 raises RESET during that cycle.
    task automatic run_instr(input instr_t in, input int abort_at, input string tag);
        phase_t     ph[$];
        bit         pass;
        logic [3:0] ctl;
        logic [1:0] fw;
        exp_t       e;
        ph = '{P_FETCH, P_DECODE};
        case (in.op)
            2'b00: begin ph.push_back(in.funct[5] ? P_EXECI : P_EXECR); ph.push_back(P_ALUWB); end
            2'b01: begin
                ph.push_back(P_MEMADR);
                if (in.funct[0]) begin ph.push_back(P_MEMREAD); ph.push_back(P_MEMWB); end
                else ph.push_back(P_MEMWRITE);
            end
            2'b10: ph.push_back(P_BRANCH);
            default: ;
        endcase
        pass = cond_ok(in.cond, model_flags[2]);
        alu_model(in.funct, ctl, fw);
        for (int i = 0; i < ph.size(); i++) begin
            @(posedge clk);
            #1;
            RESET    = (i == abort_at);
            Cond     = in.cond;
            Op       = in.op;
            Funct    = in.funct;
            Rd       = in.rd;
            ALUFlags = (ph[i] == P_EXECR || ph[i] == P_EXECI) ? in.flg : 4'($urandom);
            e.exp  = expect_out(ph[i], in, pass, ctl);
            e.name = $sformatf("%s/%s", tag, ph[i].name());
            sb_q.push_back(e);
            if ((ph[i] == P_EXECR || ph[i] == P_EXECI) && pass) begin
                if (fw[1]) model_flags[3:2] = in.flg[3:2];
                if (fw[0]) model_flags[1:0] = in.flg[1:0];
            end
            if (i == abort_at) begin
                model_flags = 4'b0000;
                break;
            end
        end
    endtask

    // Monitor: compares each cycle's outputs against the queued prediction
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            tests++;
            if (w_got !== e.exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, w_got, e.exp);
            end else begin
                $display("ok   %s: %b", e.name, w_got);
            end
        end
    end

    function automatic instr_t mk(input logic [3:0] c, input logic [1:0] o,
                                  input logic [5:0] f, input logic [3:0] r,
                                  input logic [3:0] fl);
        instr_t t;
        t.cond = c; t.op = o; t.funct = f; t.rd = r; t.flg = fl;
        return t;
    endfunction

    initial begin
        exp_t   e;
        instr_t t;
        instr_t zero_in;
        RESET = 1'b1; Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        model_flags = 4'b0000;
        zero_in = mk(4'd0, 2'd0, 6'd0, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        e.exp  = expect_out(P_FETCH, zero_in, 1'b0, 4'b0100);
        e.name = "reset/FETCH";
        sb_q.push_back(e);

        // Directed cases
        run_instr(mk(4'hE, 2'b00, 6'b101000, 4'd1, 4'b1111), -1, "ADDimm");
        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'd1, 4'b1111), -1, "ADDreg");
        run_instr(mk(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100), -1, "SUBS_z1");
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000), -1, "BEQ_taken");
        run_instr(mk(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0000), -1, "SUBS_z0");
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000), -1, "BEQ_not");
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000), -1, "LDR");
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000), -1, "STR");
        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000), -1, "ADD_pc");
        run_instr(mk(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100), -1, "SUBS_z1b");
        run_instr(mk(4'h1, 2'b00, 6'b001000, 4'd15, 4'b0000), -1, "ADDNE_pc");
        run_instr(mk(4'h5, 2'b01, 6'b011000, 4'd3, 4'b0000), -1, "STR_never");
        run_instr(mk(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000), -1, "OP11");
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'd4, 4'b0000), 3, "LDR_abort");
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000), -1, "BEQ_after_rst");
        run_instr(mk(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000), -1, "BNE_after_rst");

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       t.cond = 4'h0;
                1:       t.cond = 4'h1;
                2:       t.cond = 4'hE;
                default: t.cond = 4'($urandom);
            endcase
            t.op    = 2'($urandom);
            t.funct = 6'($urandom);
            t.rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            t.flg   = 4'($urandom);
            run_instr(t, ($urandom_range(0, 19) == 0) ? 2 : -1, $sformatf("rnd%0d", n));
        end

        repeat (2) @(negedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
